// File: rtl/tbuart_rx.sv
// ---------------------------------------------------------------------------
// tbuart_rx
//   Clocked 8N1 UART receiver acting as the bench-side console monitor for
//   the chip's UART TX pin. It assembles bytes LSB first, flags framing
//   errors, and tracks text lines terminated by '\n' (0x0A).
//
// Parameters
//   CLKS_PER_BIT  clock cycles per bit period (>= 4)
//   LEN_W         width of the line-length counter
//
// Ports
//   clock      in   system clock, rising-edge active
//   reset      in   asynchronous, active-high reset
//   ser_rx     in   serial input, idle high, asynchronous to clock
//   rx_data    out  last byte received with a good stop bit
//   rx_valid   out  one-cycle pulse when rx_data updates
//   frame_err  out  one-cycle pulse when the stop bit samples low
//   line_done  out  one-cycle pulse (with rx_valid) when the byte is 0x0A
//   line_len   out  bytes since the last '\n', excluding it; saturating
//   overflow   out  sticky; set when line_len would pass all-ones,
//                   cleared by reset or line_done
// ---------------------------------------------------------------------------
module tbuart_rx #(
    parameter int CLKS_PER_BIT = 4167,
    parameter int LEN_W        = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ser_rx,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             frame_err,
    output logic             line_done,
    output logic [LEN_W-1:0] line_len,
    output logic             overflow
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             break_wait_q, break_wait_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             line_done_q, line_done_d;
    logic [LEN_W-1:0] line_len_q, line_len_d;
    logic             overflow_q, overflow_d;
    logic             rx_s;

    // Two-flop synchronizer; both flops reset to the idle-high line level
    // so that releasing reset never looks like a start bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= ser_rx;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            break_wait_q <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            line_done_q  <= 1'b0;
            line_len_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            break_wait_q <= break_wait_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            line_done_q  <= line_done_d;
            line_len_q   <= line_len_d;
            overflow_q   <= overflow_d;
        end
    end

    // Next-state logic. The START state waits half a bit before resampling,
    // which both centres later samples in their bit cells and rejects low
    // glitches shorter than half a bit. After a framing error the line may
    // still be held low (break), so IDLE refuses new start bits until the
    // line has been seen high again.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        break_wait_d = break_wait_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        frame_err_d  = 1'b0;
        line_done_d  = 1'b0;
        line_len_d   = line_len_q;
        overflow_d   = overflow_q;

        case (state_q)
            S_IDLE: begin
                if (break_wait_q) begin
                    if (rx_s) begin
                        break_wait_d = 1'b0;
                    end
                end else if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = HALF_LOAD;
                end
            end

            S_START: begin
                if (cnt_q == '0) begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_idx_d = 3'd0;
                        cnt_d     = FULL_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = FULL_LOAD;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_STOP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    if (rx_s) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        // Line tracking moves in lockstep with rx_valid.
                        if (shift_q == 8'h0A) begin
                            line_done_d = 1'b1;
                            line_len_d  = '0;
                            overflow_d  = 1'b0;
                        end else if (&line_len_q) begin
                            overflow_d = 1'b1;
                        end else begin
                            line_len_d = line_len_q + LEN_W'(1);
                        end
                    end else begin
                        frame_err_d  = 1'b1;
                        break_wait_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign line_done = line_done_q;
    assign line_len  = line_len_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_tbuart_rx.sv
// ---------------------------------------------------------------------------
// tb_tbuart_rx
//   Self-checking bench for tbuart_rx (CLKS_PER_BIT=8, LEN_W=4). A reference
//   model predicts, for every frame sent, the event it must produce (byte or
//   framing error) and the resulting line length / overflow state. A monitor
//   pops those predictions as the DUT pulses and compares them.
// ---------------------------------------------------------------------------
module tb_tbuart_rx;

   localparam int CPB     = 8;
   localparam int LW      = 4;
   localparam int LEN_MAX = (1 << LW) - 1;

   logic          clock = 1'b0;
   logic          reset;
   logic          ser_rx;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          frame_err;
   logic          line_done;
   logic [LW-1:0] line_len;
   logic          overflow;

   tbuart_rx #(
      .CLKS_PER_BIT(CPB),
      .LEN_W       (LW)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .ser_rx   (ser_rx),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .frame_err(frame_err),
      .line_done(line_done),
      .line_len (line_len),
      .overflow (overflow)
   );

   // 100 MHz-style free-running clock.
   always #5 clock = ~clock;

   typedef struct {
      bit         isErr;
      logic [7:0] data;
      bit         done;
      int         len;
      bit         ovf;
   } expEvent_t;

   expEvent_t expQ[$];
   int        total = 0;
   int        bad   = 0;

   // Reference model state: last good byte, current line length, overflow.
   logic [7:0] mData = 8'h00;
   int         mLen  = 0;
   bit         mOvf  = 1'b0;

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Predict the event of one frame from the line rules and queue it.
   task automatic modelFrame(input logic [7:0] b, input bit stopOk);
      expEvent_t e;
      e.isErr = !stopOk;
      e.done  = 1'b0;
      if (stopOk) begin
         mData = b;
         if (b == 8'h0A) begin
            mLen   = 0;
            mOvf   = 1'b0;
            e.done = 1'b1;
         end else if (mLen == LEN_MAX) begin
            mOvf = 1'b1;
         end else begin
            mLen = mLen + 1;
         end
      end
      e.data = mData;
      e.len  = mLen;
      e.ovf  = mOvf;
      expQ.push_back(e);
   endtask

   task automatic driveBit(input logic v);
      ser_rx = v;
      repeat (CPB) @(negedge clock);
   endtask

   // Send one 8N1 frame at exact bit timing, then idle high for gap cycles.
   task automatic applyStimulus(input logic [7:0] b, input bit stopOk, input int gap);
      modelFrame(b, stopOk);
      driveBit(1'b0);
      for (int i = 0; i < 8; i++) driveBit(b[i]);
      driveBit(stopOk);
      ser_rx = 1'b1;
      repeat (gap) @(negedge clock);
   endtask

   // Short low pulse on an idle line; must produce no event at all.
   task automatic applyGlitch(input int n);
      ser_rx = 1'b0;
      repeat (n) @(negedge clock);
      ser_rx = 1'b1;
      repeat (16) @(negedge clock);
   endtask

   // Bounded wait for every predicted event to have been observed.
   task automatic waitDrain(input string tag);
      int n = 0;
      while (expQ.size() != 0 && n < 300) begin
         @(negedge clock);
         n++;
      end
      checkOutput(tag, expQ.size(), 0);
   endtask

   // Monitor: checks pulse widths/exclusivity and scores each event
   // against the model's prediction.
   logic prevValid = 1'b0;
   logic prevErr   = 1'b0;
   always @(posedge clock) begin
      expEvent_t e;
      #1;
      if (rx_valid) checkOutput("valid_width", prevValid, 0);
      if (frame_err) begin
         checkOutput("err_width", prevErr, 0);
         checkOutput("err_excl", rx_valid, 0);
      end
      if (line_done) checkOutput("done_with_valid", rx_valid, 1);
      if (rx_valid || frame_err) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_event", expQ.size(), 1);
         end else begin
            e = expQ.pop_front();
            checkOutput("event_kind", frame_err, e.isErr);
            checkOutput("rx_data", rx_data, e.data);
            checkOutput("line_done", line_done, e.done);
            checkOutput("line_len", line_len, e.len);
            checkOutput("overflow", overflow, e.ovf);
         end
      end
      prevValid = rx_valid;
      prevErr   = frame_err;
   end

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_data"}, rx_data, 0);
      checkOutput({tag, "_valid"}, rx_valid, 0);
      checkOutput({tag, "_ferr"}, frame_err, 0);
      checkOutput({tag, "_done"}, line_done, 0);
      checkOutput({tag, "_len"}, line_len, 0);
      checkOutput({tag, "_ovf"}, overflow, 0);
   endtask

   // Watchdog so the run always ends.
   initial begin
      #600000;
      $display("[TB] FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios followed by a randomized stream.
   initial begin
      logic [7:0] rb;
      int         r;
      bit         ok;
      reset  = 1'b1;
      ser_rx = 1'b1;
      repeat (3) @(negedge clock);
      checkAllZero("in_reset");
      reset = 1'b0;
      repeat (4) @(negedge clock);
      checkAllZero("after_reset");

      $display("[TB] single byte 0x41");
      applyStimulus(8'h41, 1'b1, 4);
      waitDrain("drain_41");

      $display("[TB] line AB newline");
      applyStimulus(8'h41, 1'b1, 0);
      applyStimulus(8'h42, 1'b1, 0);
      applyStimulus(8'h0A, 1'b1, 4);
      waitDrain("drain_ab");
      checkOutput("len_after_nl", line_len, 0);

      $display("[TB] framing error then recovery");
      applyStimulus(8'h55, 1'b0, 16);
      applyStimulus(8'h33, 1'b1, 4);
      waitDrain("drain_ferr");

      $display("[TB] short glitch");
      applyGlitch(3);
      checkOutput("glitch_queue", expQ.size(), 0);
      applyStimulus(8'h20, 1'b1, 4);
      waitDrain("drain_glitch");

      $display("[TB] line length saturation");
      applyStimulus(8'h0A, 1'b1, 2);
      for (int i = 0; i < 16; i++) applyStimulus(8'h61 + 8'(i), 1'b1, 1);
      waitDrain("drain_sat");
      checkOutput("sat_len", line_len, LEN_MAX);
      checkOutput("sat_ovf", overflow, 1);
      applyStimulus(8'h0A, 1'b1, 4);
      waitDrain("drain_sat_nl");
      checkOutput("sat_clr_len", line_len, 0);
      checkOutput("sat_clr_ovf", overflow, 0);

      $display("[TB] randomized frames");
      for (int k = 0; k < 40; k++) begin
         r = $urandom_range(0, 9);
         if (r == 0) begin
            applyGlitch($urandom_range(1, 3));
         end else begin
            rb = 8'($urandom);
            if ($urandom_range(0, 4) == 0) rb = 8'h0A;
            ok = (r != 1);
            applyStimulus(rb, ok, ok ? $urandom_range(0, 5) : $urandom_range(6, 12));
         end
      end
      waitDrain("drain_rand");

      $display("[TB] reset mid-frame");
      applyStimulus(8'h31, 1'b1, 4);
      waitDrain("drain_pre_reset");
      rb = 8'h7E;
      ser_rx = 1'b0;
      repeat (CPB) @(negedge clock);
      for (int i = 0; i < 4; i++) driveBit(rb[i]);
      ser_rx = rb[4];
      repeat (CPB / 2) @(negedge clock);
      reset = 1'b1;
      #1;
      checkAllZero("mid_reset");
      ser_rx = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      mData = 8'h00;
      mLen  = 0;
      mOvf  = 1'b0;
      repeat (4) @(negedge clock);
      applyStimulus(8'h7E, 1'b1, 4);
      waitDrain("drain_post_reset");
      checkOutput("post_reset_data", rx_data, 8'h7E);

      repeat (10) @(negedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
